bcd_serial_subtractor: RTL and testbench



---
 rtl/bcd_serial_subtractor_pkg.sv | 25 ++
 rtl/bcd_serial_subtractor_if.sv | 24 ++
 rtl/bcd_serial_subtractor_digit_cell.sv | 27 ++
 rtl/bcd_serial_subtractor.sv | 194 +++++++++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared definitions for the digit-serial BCD subtractor: digit width,
// FSM state encoding and small per-digit helper functions.
package bcd_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      CORR = 2'd2,
      DONE = 2'd3
   } sub_state_t;

   // Nine's complement of a single BCD digit.
   function automatic logic [BCD_W-1:0] nines_comp(input logic [BCD_W-1:0] digit);
      return BCD_NINE - digit;
   endfunction

   // True when the nibble is a legal BCD digit (0..9).
   function automatic logic is_bcd_digit(input logic [BCD_W-1:0] digit);
      return (digit <= BCD_NINE);
   endfunction

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Request/result bundle of the BCD serial subtractor.
// master drives the operands and start; slave returns the handshake and result.
interface bcd_serial_subtractor_if #(
   parameter int DIGITS = 4
) ();
   logic                  start;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
   logic                  ready;
   logic                  done;
   logic [4*DIGITS-1:0]   diff;
   logic                  neg;
   logic                  err;

   modport master (
      output start, a, b,
      input  ready, done, diff, neg, err
   );

   modport slave (
      input  start, a, b,
      output ready, done, diff, neg, err
   );
endinterface

// File: rtl/bcd_serial_subtractor_digit_cell.sv
// Single-digit decimal adder: d/cout = x + y + cin with the usual +6
// correction when the binary sum leaves the 0..9 range.
module bcd_digit_cell
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] x,
   input  logic [BCD_W-1:0] y,
   input  logic             cin,
   output logic [BCD_W-1:0] d,
   output logic             cout
);

   logic [BCD_W:0] sum_s;

   // Binary add, then fold sums above nine back into a decimal digit.
   always_comb begin
      sum_s = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
      if (sum_s > 5'd9) begin
         d    = sum_s[BCD_W-1:0] + 4'd6;
         cout = 1'b1;
      end else begin
         d    = sum_s[BCD_W-1:0];
         cout = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor producing |A-B| in sign-magnitude form.
// One digit per clock, LSD first, as A + 9c(B) + 1; a negative result is
// turned into its magnitude by a second ten's-complement pass (CORR).
// Optional macro BCD_SUB_DIGIT_CHECK_EN: reject operands holding a digit
// above nine, finishing at once with err=1, diff=0, neg=0.
module bcd_serial_subtractor
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   bcd_serial_subtractor_if.slave  bus
);

   localparam int W     = BCD_W * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   sub_state_t          state_r;
   sub_state_t          state_nxt_s;
   logic [W-1:0]        a_r;
   logic [W-1:0]        b_r;
   logic [W-1:0]        diff_r;
   logic [IDX_W-1:0]    idx_r;
   logic                carry_r;
   logic                neg_r;
   logic                ready_r;
   logic                done_r;
   logic [BCD_W-1:0]    cell_x_s;
   logic [BCD_W-1:0]    cell_y_s;
   logic [BCD_W-1:0]    cell_d_s;
   logic                cell_cout_s;
   logic                last_s;
   logic                invalid_s;

   assign last_s = (idx_r == IDX_W'(DIGITS - 1));

`ifdef BCD_SUB_DIGIT_CHECK_EN
   logic err_r;

   // Flag any non-decimal nibble on the incoming operands.
   always_comb begin
      invalid_s = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!is_bcd_digit(bus.a[i*BCD_W +: BCD_W]) || !is_bcd_digit(bus.b[i*BCD_W +: BCD_W])) begin
            invalid_s = 1'b1;
         end else begin
            invalid_s = invalid_s;
         end
      end
   end

   assign bus.err = err_r;
`else
   assign invalid_s = 1'b0;
   assign bus.err   = 1'b0;
`endif

   // Operand mux: SUB adds a + 9c(b); CORR adds 0 + 9c(diff).
   always_comb begin
      if (state_r == CORR) begin
         cell_x_s = 4'd0;
         cell_y_s = nines_comp(diff_r[idx_r*BCD_W +: BCD_W]);
      end else begin
         cell_x_s = a_r[idx_r*BCD_W +: BCD_W];
         cell_y_s = nines_comp(b_r[idx_r*BCD_W +: BCD_W]);
      end
   end

   bcd_digit_cell u_cell (
      .x    (cell_x_s),
      .y    (cell_y_s),
      .cin  (carry_r),
      .d    (cell_d_s),
      .cout (cell_cout_s)
   );

   // Next-state logic of the IDLE/SUB/CORR/DONE sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_nxt_s = invalid_s ? DONE : SUB;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SUB: begin
            if (last_s) begin
               state_nxt_s = cell_cout_s ? DONE : CORR;
            end else begin
               state_nxt_s = SUB;
            end
         end
         CORR: begin
            if (last_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = CORR;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Handshake outputs registered from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_r <= 1'b1;
         done_r  <= 1'b0;
      end else begin
         ready_r <= (state_nxt_s == IDLE);
         done_r  <= (state_nxt_s == DONE);
      end
   end

   // Operand latch, digit index, carry chain and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_r     <= '0;
         b_r     <= '0;
         diff_r  <= '0;
         idx_r   <= '0;
         carry_r <= 1'b0;
         neg_r   <= 1'b0;
`ifdef BCD_SUB_DIGIT_CHECK_EN
         err_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  a_r     <= bus.a;
                  b_r     <= bus.b;
                  idx_r   <= '0;
                  carry_r <= 1'b1;
`ifdef BCD_SUB_DIGIT_CHECK_EN
                  err_r   <= invalid_s;
                  if (invalid_s) begin
                     diff_r <= '0;
                     neg_r  <= 1'b0;
                  end
`endif
               end
            end
            SUB: begin
               diff_r[idx_r*BCD_W +: BCD_W] <= cell_d_s;
               if (last_s) begin
                  idx_r   <= '0;
                  // No borrow-free carry out means A < B: redo as ten's complement.
                  carry_r <= cell_cout_s ? 1'b0 : 1'b1;
                  neg_r   <= ~cell_cout_s;
               end else begin
                  idx_r   <= idx_r + IDX_W'(1);
                  carry_r <= cell_cout_s;
               end
            end
            CORR: begin
               diff_r[idx_r*BCD_W +: BCD_W] <= cell_d_s;
               if (last_s) begin
                  idx_r   <= '0;
                  carry_r <= 1'b0;
               end else begin
                  idx_r   <= idx_r + IDX_W'(1);
                  carry_r <= cell_cout_s;
               end
            end
            DONE: begin
               idx_r <= '0;
            end
            default: begin
               idx_r <= '0;
            end
         endcase
      end
   end

   assign bus.ready = ready_r;
   assign bus.done  = done_r;
   assign bus.diff  = diff_r;
   assign bus.neg   = neg_r;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed self-checking bench for bcd_serial_subtractor (DIGITS=4).
module tb_bcd_serial_subtractor;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   n;
   logic seen_done;

   bcd_serial_subtractor_if #(.DIGITS(4)) bus ();

   bcd_serial_subtractor #(.DIGITS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present operands in the current cycle; returns #1 after the accept edge.
   task automatic accept(input logic [15:0] av, input logic [15:0] bv);
      bus.a     = av;
      bus.b     = bv;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Counts edges after the current point until done is seen (bounded).
   task automatic wait_done(output int cnt);
      cnt = 0;
      while (bus.done !== 1'b1 && cnt < 40) begin
         @(posedge clk);
         #1;
         cnt++;
      end
   endtask

   // Full operation: accept, latency, result, then single-cycle done.
   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input int lat, input logic [15:0] exp_diff, input logic exp_neg);
      check({tag, "_ready_in"}, {31'd0, bus.ready}, 32'd1);
      accept(av, bv);
      wait_done(n);
      check({tag, "_latency"}, n, lat);
      check({tag, "_diff"}, {16'd0, bus.diff}, {16'd0, exp_diff});
      check({tag, "_neg"}, {31'd0, bus.neg}, {31'd0, exp_neg});
      check({tag, "_err"}, {31'd0, bus.err}, 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.a     = 16'h0000;
      bus.b     = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, bus.ready}, 32'd1);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_diff", {16'd0, bus.diff}, 32'd0);
      check("rst_neg", {31'd0, bus.neg}, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      run_op("pos", 16'h5432, 16'h1234, 4, 16'h4198, 1'b0);
      run_op("negv", 16'h1234, 16'h5432, 8, 16'h4198, 1'b1);
      run_op("zero_m", 16'h0000, 16'h9999, 8, 16'h9999, 1'b1);
      run_op("equal", 16'h0731, 16'h0731, 4, 16'h0000, 1'b0);

      // start pulsed mid-SUB with other operands must be ignored
      accept(16'h5432, 16'h1234);
      check("busy_ready", {31'd0, bus.ready}, 32'd0);
      @(posedge clk);
      #1;
      bus.a     = 16'h9999;
      bus.b     = 16'h0000;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(n);
      check("ign_latency", n, 2);
      check("ign_diff", {16'd0, bus.diff}, 32'h4198);
      check("ign_neg", {31'd0, bus.neg}, 32'd0);
      @(posedge clk);
      #1;
      // back-to-back request in the first ready cycle
      run_op("b2b", 16'h0100, 16'h0001, 4, 16'h0099, 1'b0);

      // asynchronous reset in the middle of SUB
      accept(16'h1234, 16'h5432);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("arst_ready", {31'd0, bus.ready}, 32'd1);
      check("arst_done", {31'd0, bus.done}, 32'd0);
      check("arst_diff", {16'd0, bus.diff}, 32'd0);
      check("arst_neg", {31'd0, bus.neg}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) seen_done = 1'b1;
      end
      check("arst_no_done", {31'd0, seen_done}, 32'd0);

      // operand with a non-decimal digit
      accept(16'h12A4, 16'h0001);
      wait_done(n);
`ifdef BCD_SUB_DIGIT_CHECK_EN
      check("inv_latency", n, 0);
      check("inv_err", {31'd0, bus.err}, 32'd1);
      check("inv_diff", {16'd0, bus.diff}, 32'd0);
      check("inv_neg", {31'd0, bus.neg}, 32'd0);
`else
      check("inv_latency", n, 4);
      check("inv_err", {31'd0, bus.err}, 32'd0);
`endif
      @(posedge clk);
      #1;
      run_op("after_inv", 16'h9000, 16'h0001, 4, 16'h8999, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
